// File: rtl/vga_fb_pkg.sv
// vga_fb_pkg: state type and default geometry shared by the
// frame-buffer arbiter and its address generators.
package vga_fb_pkg;

  localparam int unsigned FB_ADDR_W      = 22;
  localparam int unsigned FB_BURST_LEN   = 8;
  localparam int unsigned FB_FRAME_WORDS = 307200;
  localparam int unsigned FB_STARVE_MAX  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } fb_state_e;

  typedef enum logic {
    DIR_RD = 1'b0,
    DIR_WR = 1'b1
  } fb_dir_e;

endpackage

// File: rtl/fb_addr_gen.sv
// fb_addr_gen: per-requester burst address counter with frame
// wrap and a latched frame-restart request.
module fb_addr_gen
  import vga_fb_pkg::*;
#(
  parameter int unsigned ADDR_W      = FB_ADDR_W,
  parameter int unsigned BURST_LEN   = FB_BURST_LEN,
  parameter int unsigned FRAME_WORDS = FB_FRAME_WORDS
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              i_frame_start,
  input  logic              i_idle,
  input  logic              i_burst_end,
  output logic [ADDR_W-1:0] o_addr
);

  localparam logic [ADDR_W-1:0] LP_STEP =
    ADDR_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0] LP_LAST =
    ADDR_W'(FRAME_WORDS - BURST_LEN);

  logic              r_pend;
  logic [ADDR_W-1:0] r_addr;
  logic              w_pend;

  assign w_pend = r_pend | i_frame_start;

  // A grant taken this idle cycle already sees the restarted address.
  assign o_addr = (i_idle & w_pend) ? '0 : r_addr;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_addr <= '0;
      r_pend <= 1'b0;
    end else if (i_burst_end) begin
      r_pend <= 1'b0;
      if (w_pend || r_addr == LP_LAST)
        r_addr <= '0;
      else
        r_addr <= r_addr + LP_STEP;
    end else if (i_idle && w_pend) begin
      r_addr <= '0;
      r_pend <= 1'b0;
    end else if (i_frame_start) begin
      r_pend <= 1'b1;
    end
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: display-read / camera-write burst arbiter for a
// shared frame memory. Define FB_ARB_STARVE_GUARD_EN for write anti-starvation.
module vga_fb_arbiter
  import vga_fb_pkg::*;
#(
  parameter int unsigned ADDR_W      = FB_ADDR_W,
  parameter int unsigned BURST_LEN   = FB_BURST_LEN,
  parameter int unsigned FRAME_WORDS = FB_FRAME_WORDS,
  parameter int unsigned STARVE_MAX  = FB_STARVE_MAX
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iRD_REQ,
  input  logic              iWR_REQ,
  input  logic              iRD_FRAME_START,
  input  logic              iWR_FRAME_START,
  output logic              oMEM_CMD_VALID,
  output logic              oMEM_CMD_WRITE,
  output logic [ADDR_W-1:0] oMEM_ADDR,
  input  logic              iMEM_CMD_READY,
  input  logic              iMEM_BEAT,
  output logic              oRD_BEAT,
  output logic              oWR_BEAT,
  output logic              oBUSY
);

  localparam int unsigned BEAT_W = $clog2(BURST_LEN);
  localparam logic [BEAT_W-1:0] LP_LAST_BEAT =
    BEAT_W'(BURST_LEN - 1);

  if (BURST_LEN < 2 || BURST_LEN > 64 ||
      (BURST_LEN & (BURST_LEN - 1)) != 0 ||
      (FRAME_WORDS % BURST_LEN) != 0 ||
      STARVE_MAX < 1) begin : g_bad_cfg
    $error("vga_fb_arbiter: illegal parameter set");
  end

  fb_state_e         r_state;
  fb_dir_e           r_dir;
  logic [BEAT_W-1:0] r_beat;
  logic              r_cmd_valid;
  logic              r_cmd_write;
  logic [ADDR_W-1:0] r_cmd_addr;

  logic [ADDR_W-1:0] w_rd_addr;
  logic [ADDR_W-1:0] w_wr_addr;
  logic              w_idle;
  logic              w_data;
  logic              w_accept;
  logic              w_last;
  logic              w_rd_end;
  logic              w_wr_end;
  logic              w_grant;
  logic              w_grant_wr;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_data   = (r_state == ST_DATA);
  assign w_accept = r_cmd_valid & iMEM_CMD_READY;
  assign w_last   = w_data & iMEM_BEAT &
                    (r_beat == LP_LAST_BEAT);
  assign w_rd_end = w_last & (r_dir == DIR_RD);
  assign w_wr_end = w_last & (r_dir == DIR_WR);
  assign w_grant  = w_idle & (iRD_REQ | iWR_REQ);

`ifdef FB_ARB_STARVE_GUARD_EN
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] LP_SMAX = SW'(STARVE_MAX);

  logic [SW-1:0] r_starve;
  logic          w_starved;

  assign w_starved  = iWR_REQ & (r_starve == LP_SMAX);
  assign w_grant_wr = w_starved | (~iRD_REQ & iWR_REQ);

  // Counts read grants taken while a write is waiting.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_starve <= '0;
    end else if (w_idle) begin
      if (!iWR_REQ || w_grant_wr)
        r_starve <= '0;
      else if (iRD_REQ && r_starve != LP_SMAX)
        r_starve <= r_starve + SW'(1);
    end
  end
`else
  assign w_grant_wr = ~iRD_REQ & iWR_REQ;
`endif

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state     <= ST_IDLE;
      r_dir       <= DIR_RD;
      r_beat      <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd_write <= 1'b0;
      r_cmd_addr  <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_state     <= ST_CMD;
            r_dir       <= w_grant_wr ? DIR_WR : DIR_RD;
            r_beat      <= '0;
            r_cmd_valid <= 1'b1;
            r_cmd_write <= w_grant_wr;
            r_cmd_addr  <= w_grant_wr ? w_wr_addr : w_rd_addr;
          end
        end
        ST_CMD: begin
          if (w_accept) begin
            r_state     <= ST_DATA;
            r_cmd_valid <= 1'b0;
            r_cmd_write <= 1'b0;
            r_cmd_addr  <= '0;
          end
        end
        ST_DATA: begin
          if (iMEM_BEAT) begin
            r_beat <= r_beat + BEAT_W'(1);
            if (r_beat == LP_LAST_BEAT)
              r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  fb_addr_gen #(
    .ADDR_W     (ADDR_W),
    .BURST_LEN  (BURST_LEN),
    .FRAME_WORDS(FRAME_WORDS)
  ) u_rd_addr (
    .iCLK         (iCLK),
    .iRST_N       (iRST_N),
    .i_frame_start(iRD_FRAME_START),
    .i_idle       (w_idle),
    .i_burst_end  (w_rd_end),
    .o_addr       (w_rd_addr)
  );

  fb_addr_gen #(
    .ADDR_W     (ADDR_W),
    .BURST_LEN  (BURST_LEN),
    .FRAME_WORDS(FRAME_WORDS)
  ) u_wr_addr (
    .iCLK         (iCLK),
    .iRST_N       (iRST_N),
    .i_frame_start(iWR_FRAME_START),
    .i_idle       (w_idle),
    .i_burst_end  (w_wr_end),
    .o_addr       (w_wr_addr)
  );

  assign oMEM_CMD_VALID = r_cmd_valid;
  assign oMEM_CMD_WRITE = r_cmd_write;
  assign oMEM_ADDR      = r_cmd_addr;
  assign oRD_BEAT       = w_data & (r_dir == DIR_RD) & iMEM_BEAT;
  assign oWR_BEAT       = w_data & (r_dir == DIR_WR) & iMEM_BEAT;
  assign oBUSY          = ~w_idle;

endmodule

// File: doc/vga_fb_arbiter.md
VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, 22, frame-memory word-address width.
REQ-002 SHALL have parameter BURST_LEN, 8, words per burst (power of 2, 2..64).
REQ-003 SHALL have parameter FRAME_WORDS, 307200, words per frame (multiple of BURST_LEN).
REQ-004 SHALL have parameter STARVE_MAX, 4, consecutive read bursts allowed while write waits.
REQ-005 SHALL have ports: iCLK in 1 clock; iRST_N in 1 asynchronous active-low reset.
REQ-006 SHALL have ports: iRD_REQ in 1 display FIFO below low-water; iWR_REQ in 1 camera FIFO holds >= BURST_LEN words.
REQ-007 SHALL have ports: iRD_FRAME_START in 1 display-frame restart pulse; iWR_FRAME_START in 1 camera-frame restart pulse.
REQ-008 SHALL have ports: oMEM_CMD_VALID out 1; oMEM_CMD_WRITE out 1; oMEM_ADDR out ADDR_W; iMEM_CMD_READY in 1 command accept.
REQ-009 SHALL have ports: iMEM_BEAT in 1 one-word data strobe; oRD_BEAT out 1 push to display FIFO; oWR_BEAT out 1 pop from camera FIFO; oBUSY out 1 burst in progress.

Function
REQ-010 SHALL implement states IDLE, CMD, DATA; IDLE->CMD on grant, CMD->DATA on oMEM_CMD_VALID & iMEM_CMD_READY, DATA->IDLE on BURST_LEN-th beat.
REQ-011 SHALL grant in IDLE: read if iRD_REQ, else write if iWR_REQ; exception: write wins if iWR_REQ and starve count == STARVE_MAX.
REQ-012 SHALL assert oMEM_CMD_VALID the cycle after the IDLE grant; oMEM_CMD_WRITE and oMEM_ADDR held stable until accept.
REQ-013 SHALL drive oMEM_ADDR from the granted requester's address counter; oMEM_ADDR = 0 when not in CMD.
REQ-014 SHALL count iMEM_BEAT only in DATA; oRD_BEAT = iMEM_BEAT in read DATA, oWR_BEAT = iMEM_BEAT in write DATA, combinational, zero elsewhere.
REQ-015 SHALL ignore iMEM_BEAT in IDLE and CMD.
REQ-016 SHALL on burst end add BURST_LEN to that requester's address; FRAME_WORDS-BURST_LEN wraps to 0.
REQ-017 SHALL latch each frame-start pulse into a pending flag; in IDLE, pending flag zeroes its address and clears itself.
REQ-018 SHALL, if a frame-start arrives during that requester's burst, finish the burst and load address 0 instead of incrementing.
REQ-019 SHALL give pending-flag application in IDLE priority over grant: the grant in that cycle uses address 0.
REQ-020 SHALL increment starve count on each read grant made while iWR_REQ = 1 (saturating at STARVE_MAX); clear it on write grant or iWR_REQ = 0 in IDLE.
REQ-021 SHALL assert oBUSY in CMD and DATA; minimum one IDLE cycle between bursts.

Reset
REQ-022 SHALL on iRST_N low immediately enter IDLE, clear addresses, beat count, starve count, pending flags; all outputs 0.
REQ-023 SHALL abort any in-flight burst on reset with no address update; first post-reset grant uses address 0.

Configuration
REQ-024 SHALL with FB_ARB_STARVE_GUARD_EN defined implement REQ-011 exception and REQ-020 counter.
REQ-025 SHALL without FB_ARB_STARVE_GUARD_EN use strict read priority, omit the starve counter; STARVE_MAX unused.

Structure
REQ-026 SHALL place state enum, ADDR_W/BURST_LEN/FRAME_WORDS defaults in shared package vga_fb_pkg.
REQ-027 SHALL instantiate sub-module fb_addr_gen twice (read, write): address counter with increment, wrap, frame restart.

Verification
REQ-028 SHALL test: iRD_REQ=1, ready immediate, 8 beats -> CMD at addr 0, 8 oRD_BEAT pulses, next read CMD at addr 8.
REQ-029 SHALL test: iRD_REQ and iWR_REQ held 1 with guard enabled -> grants R,R,R,R,W,R,R,R,R,W; guard disabled -> reads only.
REQ-030 SHALL test: read address 307192, burst completes -> next read CMD addr 0.
REQ-031 SHALL test: iWR_FRAME_START pulse at beat 3 of write burst at addr 64 -> burst finishes 8 beats, next write CMD addr 0.
REQ-032 SHALL test: iMEM_CMD_READY low 5 cycles -> oMEM_CMD_VALID, addr, write flag stable 6 cycles; iMEM_BEAT in CMD produces no oRD_BEAT/oWR_BEAT.
REQ-033 SHALL test: reset asserted at beat 4 of read burst at addr 16 -> outputs 0 at once; after release first read CMD addr 0.
